dmem_bridge: RTL

Data-side memory bridge between the core's data port (enable, write mask, address, write data, read data) and an SRAM-like handshaked data bus (req/addr_ok/data_ok). It registers one access, drives the bus handshake, and stalls the core until the response returns. It sits directly downstream of the core's memory stage. The core's data port carries no back-pressure, so this block supplies the stall.

---
 rtl/dmem_bridge.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge
//   Data-side bridge from the core's memory stage to an SRAM-like bus with a
//   req/addr_ok/data_ok handshake. It registers one access at a time and drives
//   the bus. Because the core's data port has no back-pressure, this block
//   raises cpu_stall until the response has come back.
//
// Ports
//   clka          clock; all state changes on the rising edge
//   rst           synchronous reset, active-low
//   cpu_en        core requests a data access this cycle
//   cpu_wmask     byte write mask, 4'b0000 = read
//   cpu_addr      virtual byte address
//   cpu_wdata     lane-aligned store data
//   flush         memory-stage flush (exception / branch)
//   cpu_rdata     registered load data (raw word)
//   cpu_stall     stall request to the core pipeline
//   bus_req       bus request, high only while waiting for acceptance
//   bus_wr        1 = write
//   bus_size      0 = byte, 1 = half, 2 = word
//   bus_addr      physical byte address
//   bus_wstrb     byte strobes (0 on reads)
//   bus_wdata     write data
//   bus_addr_ok   request accepted this cycle
//   bus_data_ok   response (read data or write ack) this cycle
//   bus_rdata     read data, valid with bus_data_ok
//   busy_cycles   saturating count of stalled cycles
//
// state | meaning
// IDLE  | no access in flight; accepts cpu_en when not flushed
// REQ   | bus_req high, bus fields held until addr_ok
// WAIT  | request accepted, waiting for data_ok
// DONE  | one cycle with the result visible, stall released

module dmem_bridge #(
    parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wmask,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        flush,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic [15:0] busy_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_discard;
    logic        r_bus_req;
    logic        r_bus_wr;
    logic [1:0]  r_bus_size;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_wstrb;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_cpu_rdata;
    logic [15:0] r_busy;

    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic        w_accept;
    logic        w_stall;
    logic        w_discard;
    logic [31:0] w_phys;

    // Transfer size and low address bits follow from the mask alone; any
    // irregular mask is issued as a word access with strobes passed through.
    always_comb begin
        w_size = 2'd2;
        w_off  = 2'd0;
        case (cpu_wmask)
            4'b0011: begin w_size = 2'd1; w_off = 2'd0; end
            4'b1100: begin w_size = 2'd1; w_off = 2'd2; end
            4'b0001: begin w_size = 2'd0; w_off = 2'd0; end
            4'b0010: begin w_size = 2'd0; w_off = 2'd1; end
            4'b0100: begin w_size = 2'd0; w_off = 2'd2; end
            4'b1000: begin w_size = 2'd0; w_off = 2'd3; end
            default: begin w_size = 2'd2; w_off = 2'd0; end
        endcase
    end

    assign w_phys    = (cpu_addr & PHYS_MASK & 32'hFFFF_FFFC) | {30'd0, w_off};
    assign w_accept  = (r_state == IDLE) && cpu_en && !flush;
    assign w_stall   = w_accept || (r_state == REQ) || (r_state == WAIT);
    // A flush arriving on the completing cycle itself also drops the result.
    assign w_discard = r_discard || flush;

    always_ff @(posedge clka) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_discard   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_size  <= 2'd0;
            r_bus_addr  <= 32'd0;
            r_bus_wstrb <= 4'd0;
            r_bus_wdata <= 32'd0;
            r_cpu_rdata <= 32'd0;
            r_busy      <= 16'd0;
        end else begin
            if (w_stall && (r_busy != 16'hFFFF)) begin
                r_busy <= r_busy + 16'd1;
            end

            case (r_state)
                IDLE: begin
                    r_discard <= 1'b0;
                    if (w_accept) begin
                        r_bus_wr    <= |cpu_wmask;
                        r_bus_size  <= w_size;
                        r_bus_addr  <= w_phys;
                        r_bus_wstrb <= cpu_wmask;
                        r_bus_wdata <= cpu_wdata;
                        r_bus_req   <= 1'b1;
                        r_state     <= REQ;
                    end
                end

                REQ: begin
                    if (flush) begin
                        r_discard <= 1'b1;
                    end
                    // data_ok before acceptance belongs to nothing we issued.
                    if (bus_addr_ok) begin
                        r_bus_req <= 1'b0;
                        if (bus_data_ok) begin
                            if (w_discard) begin
                                r_discard <= 1'b0;
                                r_state   <= IDLE;
                            end else begin
                                if (!r_bus_wr) begin
                                    r_cpu_rdata <= bus_rdata;
                                end
                                r_state <= DONE;
                            end
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (flush) begin
                        r_discard <= 1'b1;
                    end
                    if (bus_data_ok) begin
                        if (w_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            if (!r_bus_wr) begin
                                r_cpu_rdata <= bus_rdata;
                            end
                            r_state <= DONE;
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_stall   = w_stall;
    assign bus_req     = r_bus_req;
    assign bus_wr      = r_bus_wr;
    assign bus_size    = r_bus_size;
    assign bus_addr    = r_bus_addr;
    assign bus_wstrb   = r_bus_wstrb;
    assign bus_wdata   = r_bus_wdata;
    assign cpu_rdata   = r_cpu_rdata;
    assign busy_cycles = r_busy;

endmodule
